// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result handshake bundle between the execute stage and muldiv_unit
interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_func3;
  logic            in_word;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            busy;

  modport master (
    output in_valid, in_func3, in_word, in_rd, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, busy
  );

  modport slave (
    input  in_valid, in_func3, in_word, in_rd, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RISC-V M-extension unit: fixed-latency multiplier, restoring divider
module muldiv_unit #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 2
) (
  input logic         clk,
  input logic         RESET,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN + MUL_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      func3_q;
  logic            word_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            div_init_q;
  logic            neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_result_q;
  logic [4:0]      out_rd_q;

  logic            eff_word, op_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg;
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0] mul_res;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            qbit;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [XLEN-1:0] quo_fix, rem_fix, div_sel, div_res;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;

  always_comb begin
    eff_word  = (XLEN == 64) && word_q;
    op_signed = ~func3_q[2] | ~func3_q[0];

    a_ext = a_q;
    b_ext = b_q;
    if (eff_word) begin
      a_ext = op_signed ? sext32(a_q[31:0]) : XLEN'(a_q[31:0]);
      b_ext = op_signed ? sext32(b_q[31:0]) : XLEN'(b_q[31:0]);
    end

    // MULH reads rs1 signed, MULHSU reads rs1 signed / rs2 unsigned
    mul_a = {{XLEN{(func3_q[1] ^ func3_q[0]) & a_ext[XLEN-1]}}, a_ext};
    mul_b = {{XLEN{(func3_q[1:0] == 2'b01) & b_ext[XLEN-1]}}, b_ext};
    prod  = mul_a * mul_b;
    if (func3_q[1:0] == 2'b00)
      mul_res = eff_word ? sext32(prod[31:0]) : prod[XLEN-1:0];
    else
      mul_res = eff_word ? '0 : prod[2*XLEN-1:XLEN];

    a_neg    = op_signed & a_ext[XLEN-1];
    b_neg    = op_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    min_neg  = eff_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    div_ovf  = op_signed && (a_ext == min_neg) && (b_ext == '1);

    // Borrow out of the trial subtraction decides the quotient bit
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, dvs_q};
    qbit     = ~rem_diff[XLEN];
    rem_d    = qbit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_d    = {quo_q[XLEN-2:0], qbit};

    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    div_sel = func3_q[1] ? rem_fix : quo_fix;
    div_res = eff_word ? sext32(div_sel[31:0]) : div_sel;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      func3_q      <= '0;
      word_q       <= 1'b0;
      rd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      div_init_q   <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else if (bus.flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      div_init_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            func3_q    <= bus.in_func3;
            word_q     <= bus.in_word;
            rd_q       <= bus.in_rd;
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            cnt_q      <= CW'(MUL_CYCLES - 1);
            div_init_q <= bus.in_func3[2];
            state_q    <= bus.in_func3[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            out_result_q <= mul_res;
            out_rd_q     <= rd_q;
            out_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          if (div_init_q) begin
            div_init_q <= 1'b0;
            rem_q      <= '0;
            dvs_q      <= b_abs;
            // Special cases load final values and fall straight to the fixup cycle
            if (div_zero) begin
              quo_q     <= '1;
              rem_q     <= a_ext;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              cnt_q     <= '0;
            end else if (div_ovf) begin
              quo_q     <= a_ext;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              cnt_q     <= '0;
            end else begin
              quo_q     <= eff_word ? (a_abs << (XLEN - 32)) : a_abs;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt_q     <= eff_word ? CW'(32) : CW'(XLEN);
            end
          end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            out_result_q <= div_res;
            out_rd_q     <= rd_q;
            out_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
